fw_tile_feeder: RTL

- Upstream stage of the fw core. Accepts 64-bit words (four packed 16-bit distances) from the host/DMA side over a valid/ready handshake.
- Assembles them into complete tiles in a two-slot ping-pong buffer.
- Streams each complete tile contiguously into fw (inD/in_valid/phase) and honours fw's inhibit back-pressure.
- Guarantees fw never sees a partial tile or a gap caused by host starvation.

---
 rtl/fw_tile_feeder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fw_tile_feeder.sv
// fw_tile_feeder: collects host words into a two-slot ping-pong tile buffer
// and streams each complete tile contiguously into the fw core.
// Handshakes:
//   host side : a word transfers on a rising edge where host_valid && host_ready.
//   fw side   : the word on inD transfers on a rising edge where in_valid is high;
//               in_valid is low whenever inhibit is high, and inD/phase hold.
module fw_tile_feeder #(
  parameter int DATA_W     = 64,
  parameter int TILE_WORDS = 16,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [1:0]        host_phase,
  output logic [DATA_W-1:0] inD,
  output logic              in_valid,
  output logic [1:0]        phase,
  input  logic              inhibit,
  output logic [1:0]        tiles_pending
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TILE_WORDS - 1);

  logic [DATA_W-1:0] mem_q [2][TILE_WORDS];

  logic              wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [1:0]        full_q, full_d;
  logic [1:0][1:0]   slot_phase_q, slot_phase_d;
  logic              host_ready_q, host_ready_d;

  state_t            state_q, state_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0] ind_q, ind_d;
  logic [1:0]        phase_q, phase_d;

  logic wr_en;
  logic wr_last;
  logic rd_fire;
  logic rd_last;

  assign wr_en   = host_valid && host_ready_q;
  assign wr_last = wr_en && (wr_cnt_q == CNT_LAST);
  assign rd_fire = (state_q == STREAM) && !inhibit;
  assign rd_last = rd_fire && (rd_cnt_q == CNT_LAST);

  // Tile storage: data words only, no reset needed since full flags gate reads.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q][wr_cnt_q] <= host_data;
    end
  end

  // Write side and slot bookkeeping; host_ready looks at next-state flags so it
  // drops the cycle after a tile completes into an already-full other slot.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    wr_cnt_d     = wr_cnt_q;
    slot_phase_d = slot_phase_q;
    full_d       = full_q;
    if (wr_en) begin
      if (wr_cnt_q == CNT_ZERO) begin
        slot_phase_d[wr_ptr_q] = host_phase;
      end
      wr_cnt_d = wr_cnt_q + CNT_ONE;
      if (wr_last) begin
        wr_ptr_d         = ~wr_ptr_q;
        full_d[wr_ptr_q] = 1'b1;
      end
    end
    if (rd_last) begin
      full_d[rd_ptr_q] = 1'b0;
    end
    host_ready_d = !full_d[wr_ptr_d];
  end

  // Read FSM: load word 0 on entry, advance on each consumed word, and chain
  // straight into the other slot when it is already full.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    rd_cnt_d = rd_cnt_q;
    ind_d    = ind_q;
    phase_d  = phase_q;
    case (state_q)
      IDLE: begin
        if (full_q[rd_ptr_q]) begin
          state_d  = STREAM;
          rd_cnt_d = CNT_ZERO;
          ind_d    = mem_q[rd_ptr_q][CNT_ZERO];
          phase_d  = slot_phase_q[rd_ptr_q];
        end
      end
      STREAM: begin
        if (!inhibit) begin
          if (rd_cnt_q == CNT_LAST) begin
            rd_ptr_d = ~rd_ptr_q;
            rd_cnt_d = CNT_ZERO;
            if (full_q[~rd_ptr_q]) begin
              ind_d   = mem_q[~rd_ptr_q][CNT_ZERO];
              phase_d = slot_phase_q[~rd_ptr_q];
            end else begin
              state_d = IDLE;
            end
          end else begin
            rd_cnt_d = rd_cnt_q + CNT_ONE;
            ind_d    = mem_q[rd_ptr_q][rd_cnt_q + CNT_ONE];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops every buffered and partial tile.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= 1'b0;
      wr_cnt_q     <= '0;
      full_q       <= '0;
      slot_phase_q <= '1;
      host_ready_q <= 1'b0;
      state_q      <= IDLE;
      rd_ptr_q     <= 1'b0;
      rd_cnt_q     <= '0;
      ind_q        <= '0;
      phase_q      <= 2'b11;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      wr_cnt_q     <= wr_cnt_d;
      full_q       <= full_d;
      slot_phase_q <= slot_phase_d;
      host_ready_q <= host_ready_d;
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_cnt_q     <= rd_cnt_d;
      ind_q        <= ind_d;
      phase_q      <= phase_d;
    end
  end

  assign host_ready    = host_ready_q;
  assign inD           = ind_q;
  assign in_valid      = (state_q == STREAM) && !inhibit;
  assign phase         = phase_q;
  assign tiles_pending = {full_q[0] & full_q[1], full_q[0] ^ full_q[1]};

endmodule
